// File: rtl/xor_serial_arbiter_if.sv
// Request/response bundle between operand producers and the shared
// serial XOR sequencer. The master side owns requests and response
// acceptance; the slave side owns grants and the result.
interface xor_serial_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int ID_W = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_data;
    logic [ID_W-1:0]        rsp_id;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/xor_serial_arbiter.sv
// Round-robin sequencer for a single NAND-built XOR bit cell shared by
// N_REQ requesters. A granted operand pair is streamed LSB-first through
// the cell, one bit per clock, and the word result is returned tagged
// with the owning requester index.
module xor_serial_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    xor_serial_arbiter_if.slave   bus
);
    localparam int ID_W  = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic [WIDTH-1:0]   data_q;
    logic [ID_W-1:0]    id_q;
    logic               valid_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt;

    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    gid;
    logic [ID_W-1:0]    gnext;
    logic [ID_W-1:0]    idx;
    logic               gfound;
    logic               accept;

    logic               n_ab;
    logic               n_a;
    logic               n_b;
    logic               xbit;

    // Insert a new result bit at the MSB so the word ends LSB-aligned.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word,
                                                  input logic bit_in);
        logic [WIDTH-1:0] tmp;
        tmp = word >> 1;
        tmp[WIDTH-1] = bit_in;
        return tmp;
    endfunction

    // The one shared XOR cell: four NAND gates on the operand LSBs.
    assign n_ab = ~(sh_a[0] & sh_b[0]);
    assign n_a  = ~(sh_a[0] & n_ab);
    assign n_b  = ~(sh_b[0] & n_ab);
    assign xbit = ~(n_a & n_b);

    // Round-robin search starting at ptr; grants only in IDLE outside reset.
    always_comb begin
        grant  = '0;
        gid    = '0;
        gfound = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (!gfound && bus.req_valid[idx]) begin
                gfound = 1'b1;
                gid    = idx;
            end
        end
        gnext = (int'(gid) == N_REQ - 1) ? '0 : gid + ID_W'(1);
        if (gfound && (state == IDLE) && !rst) begin
            grant[gid] = 1'b1;
        end
    end

    assign accept = |(grant & bus.req_valid);

    // Sequencer: accept one request, stream it through the cell, hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh_a   <= bus.req_a[gid*WIDTH +: WIDTH];
                        sh_b   <= bus.req_b[gid*WIDTH +: WIDTH];
                        id_q   <= gid;
                        cnt    <= '0;
                        ptr    <= gnext;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    data_q <= shift_in(data_q, xbit);
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/xor_serial_arbiter.md
# xor_serial_arbiter

Shares one structural NAND-based XOR bit cell between `N_REQ` requesters, each submitting a `WIDTH`-bit operand pair. A round-robin arbiter grants one request at a time. The operands are pushed through the single XOR cell LSB-first, one bit per clock. The result is returned on a valid/ready response port tagged with the requester index. The block sits between operand producers and the shared gate-level XOR datapath and is its only sequencer.

## Interface
- `N_REQ`, 4: number of requesters (≥2).
- `WIDTH`, 8: operand and result width in bits (≥1).
- `ID_W` (localparam): max(1, clog2(`N_REQ`)).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  `N_REQ`  per-requester request valid.
- `req_a`  in  `N_REQ*WIDTH`  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  `N_REQ*WIDTH`  operand B; same packing as `req_a`.
- `req_ready`  out  `N_REQ`  one-hot grant; the request is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  `WIDTH`  A XOR B of the accepted request.
- `rsp_id`  out  `ID_W`  index of the requester that owns `rsp_data`.
- `busy`  out  1  high in CALC and DONE.

## Operation
- FSM states:
  - IDLE: `req_ready` is the combinational one-hot winner among `req_valid`, searched round-robin starting at `ptr`. It is all-zero if no request is valid or while `rst` is high. On acceptance of requester g: latch `req_a`/`req_b` slices into shift registers, `rsp_id`<=g, bit counter<=0, `ptr`<=(g+1) mod `N_REQ`, go to CALC.
  - CALC: one XOR-cell instance is fed with the shift-register LSBs. Each cycle its output is shifted into `rsp_data` at the MSB (ending LSB-aligned), the operands shift right, and the counter increments. When the counter reaches `WIDTH-1` after the shift, go to DONE.
  - DONE: `rsp_valid`=1. `rsp_data` and `rsp_id` are held stable. On `rsp_valid & rsp_ready`, go to IDLE.
- `req_ready` is 0 in CALC and DONE. Requests that are not accepted stay pending and are not dropped.
- A requester deasserting `req_valid` after acceptance has no effect on the operation in progress.
- Only one XOR cell exists. No parallel XOR on the full word is permitted.
- `ptr` wraps from `N_REQ-1` to 0.

## Timing
- Reset values: state IDLE, `ptr`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0, `req_ready`=0.
- Accept in cycle T → CALC during T+1..T+`WIDTH` → `rsp_valid` high from T+`WIDTH`+1.
- Response handshake in cycle R → IDLE in R+1, where the next acceptance can occur. The minimum period is `WIDTH`+2 cycles per operation.
- `rst` asserted in any state aborts the operation on the next edge. No response is produced and all outputs return to their reset values.
- `rsp_ready` high outside DONE is ignored.

## Test plan
- Reset, then requester 2 alone with a=8'hA5, b=8'h3C accepted at T → `rsp_valid` at T+9, `rsp_data`=8'h99, `rsp_id`=2, `busy` high T+1..T+9.
- All four `req_valid` held high after reset, `rsp_ready`=1 → grants 0,1,2,3,0 in order, each with `rsp_id` matching, spaced 10 cycles apart.
- Only requesters 0 and 3 held valid → grant sequence 0,3,0,3, with `ptr` wrapping 3→0.
- Hold `rsp_ready` low 5 cycles in DONE → `rsp_valid`/`rsp_data`/`rsp_id` stable, `req_ready`=0 throughout; completes on the first `rsp_ready` cycle.
- Assert `rst` for one cycle during CALC bit 4 → next cycle `busy`=0, `rsp_valid`=0, `ptr`=0, no response ever emitted for the aborted request.
- Operand corners a=FF,b=FF → 00; a=00,b=FF → FF; a=80,b=01 → 81 (checks bit order).
